sweep_line_buffer: RTL and testbench
====================================

SWEEP_LINE_BUFFER -- requirements
Module: sweep_line_buffer

Interface
REQ-001 Parameter SIZE_ARINC, default 512, is the number of range samples per sweep line.
REQ-002 Parameter DATA_W, default 8, is the width of each range sample.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high; one clock domain only.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block accepts word; transfer occurs when in_valid && in_ready.
REQ-007 in_sof  input  1  word is a line header.
REQ-008 in_data  input  12  header: angle[11:0]; sample word: [DATA_W-1:0] used, rest ignored.
REQ-009 angle  output  12  angle of the line currently published to the consumer.
REQ-010 line_ready  output  1  a published line has unread samples.
REQ-011 FIFO_READ  input  1  consumer pop, one sample per cycle high.
REQ-012 sample_out  output  DATA_W  popped sample, registered.
REQ-013 sample_valid  output  1  sample_out valid this cycle.
REQ-014 err_short, err_dup, err_underflow  output  1 each  single-cycle error pulses.

Function
REQ-015 Storage is two banks of SIZE_ARINC x DATA_W (ping-pong); write side fills one bank while read side drains the other.
REQ-016 Write FSM states: W_IDLE (wait header), W_FILL (count samples), W_HOLD (bank full, awaiting release).
REQ-017 W_IDLE: accepted word with in_sof stores angle and goes to W_FILL, write count 0; accepted non-sof words are discarded.
REQ-018 W_FILL: each accepted non-sof word is written at the write count, which then increments; the SIZE_ARINC-th sample moves to W_HOLD.
REQ-019 W_FILL: accepted in_sof aborts the partial line, pulses err_short, loads the new angle, restarts count at 0.
REQ-020 in_ready is high in W_IDLE and W_FILL, low in W_HOLD.
REQ-021 W_HOLD: if the read side is empty, the bank is published next cycle and the write side returns to W_IDLE on the other bank.
REQ-022 A completed line whose angle equals the currently published angle is dropped (bank freed, err_dup pulse); angle does not change.
REQ-023 Publishing updates angle and sets line_ready in the same cycle; angle holds between publications, so every change marks a new line.
REQ-024 Read side: FIFO_READ with line_ready pops the next sample; sample_out and sample_valid appear exactly 1 cycle later.
REQ-025 After the SIZE_ARINC-th pop, line_ready deasserts next cycle and the bank is released; a held line is published the following cycle.
REQ-026 FIFO_READ without line_ready: no pop, sample_valid low, err_underflow pulses.
REQ-027 Simultaneous last pop and write-side completion: release first, publish the next cycle; no sample is lost or duplicated.
REQ-028 Counters are $clog2(SIZE_ARINC)+1 bits; no wrap inside a line.

Reset
REQ-029 rst clears: write FSM to W_IDLE, bank select 0, counters 0, angle 12'h000, line_ready 0, sample_valid 0, sample_out 0, in_ready 1, error pulses 0.
REQ-030 rst mid-line discards all stored data; RAM contents need not be cleared.

Structure
REQ-031 Shared package sweep_pkg holds SIZE_ARINC, DATA_W, ANGLE_W=12 and the write-FSM state enum.
REQ-032 One sub-module, sweep_bank_ram (simple dual-port, 1-cycle registered read), instantiated twice.

Verification
REQ-033 Header 0x010 + 512 samples 0..511 mod 256 -> angle 0x010, line_ready 1; 512 pops return 0..255,0..255 with 1-cycle latency.
REQ-034 Two full lines (0x010, 0x011) sent back-to-back without pops -> in_ready low after the second; 512 pops -> angle becomes 0x011 two cycles after the last pop.
REQ-035 Header 0x020, 100 samples, header 0x021, 512 samples -> one err_short pulse; published angle 0x021.
REQ-036 Line 0x030 published, then another line 0x030 -> err_dup pulse, angle stays 0x030, line_ready unaffected.
REQ-037 FIFO_READ high with no line -> err_underflow each cycle, sample_valid 0.
REQ-038 rst asserted after 300 of 512 pops -> all outputs at reset values asynchronously; new line afterwards behaves as REQ-033.

Source files
------------

// File: rtl/sweep_line_buffer_pkg.sv
// Shared sizing constants and write-side FSM encoding for the sweep line buffer.
package sweep_pkg;

  localparam int unsigned SIZE_ARINC = 512;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ANGLE_W    = 12;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_HOLD = 2'd2
  } w_state_t;

endpackage

// File: rtl/sweep_line_buffer_if.sv
// Upstream word stream: headers (in_sof) carry the angle, other words carry samples.
interface sweep_line_buffer_if;
  import sweep_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_sof;
  logic [ANGLE_W-1:0] in_data;

  modport master (output in_valid, output in_sof, output in_data, input in_ready);
  modport slave  (input in_valid, input in_sof, input in_data, output in_ready);

endinterface

// File: rtl/sweep_bank_ram.sv
// One line bank: simple dual-port storage with a registered, resettable read port.
module sweep_bank_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register resets so the published sample output starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sweep_line_buffer.sv
// Ping-pong sweep line buffer: one bank fills from the header/sample stream
// while the other is drained by the consumer one sample per pop.
module sweep_line_buffer #(
  parameter int unsigned SIZE_ARINC = sweep_pkg::SIZE_ARINC,
  parameter int unsigned DATA_W     = sweep_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  sweep_line_buffer_if.slave            up,
  output logic [sweep_pkg::ANGLE_W-1:0] angle,
  output logic                          line_ready,
  input  logic                          FIFO_READ,
  output logic [DATA_W-1:0]             sample_out,
  output logic                          sample_valid,
  output logic                          err_short,
  output logic                          err_dup,
  output logic                          err_underflow
);
  import sweep_pkg::*;

  localparam int unsigned AW    = $clog2(SIZE_ARINC);
  localparam int unsigned CNT_W = $clog2(SIZE_ARINC) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE_ARINC - 1);

  w_state_t           w_state;
  logic               wr_bank;
  logic               rd_bank;
  logic               rd_sel;
  logic [CNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]   rcnt;
  logic [ANGLE_W-1:0] wr_angle;
  logic [DATA_W-1:0]  rdata0;
  logic [DATA_W-1:0]  rdata1;
  logic               accept;
  logic               wr_en;
  logic               pop;

  assign accept = up.in_valid && up.in_ready;
  assign wr_en  = accept && !up.in_sof && (w_state == W_FILL);
  assign pop    = FIFO_READ && line_ready;

  sweep_bank_ram #(.DEPTH(SIZE_ARINC), .WIDTH(DATA_W)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en && !wr_bank),
    .waddr (wcnt[AW-1:0]),
    .wdata (up.in_data[DATA_W-1:0]),
    .re    (pop && !rd_bank),
    .raddr (rcnt[AW-1:0]),
    .rdata (rdata0)
  );

  sweep_bank_ram #(.DEPTH(SIZE_ARINC), .WIDTH(DATA_W)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en && wr_bank),
    .waddr (wcnt[AW-1:0]),
    .wdata (up.in_data[DATA_W-1:0]),
    .re    (pop && rd_bank),
    .raddr (rcnt[AW-1:0]),
    .rdata (rdata1)
  );

  // rd_sel remembers which bank the last pop read, so a bank swap after the
  // final pop cannot disturb the sample already in flight.
  assign sample_out = rd_sel ? rdata1 : rdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_sel        <= 1'b0;
      wcnt          <= '0;
      rcnt          <= '0;
      wr_angle      <= '0;
      angle         <= '0;
      line_ready    <= 1'b0;
      sample_valid  <= 1'b0;
      up.in_ready   <= 1'b1;
      err_short     <= 1'b0;
      err_dup       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_short     <= 1'b0;
      err_dup       <= 1'b0;
      sample_valid  <= pop;
      err_underflow <= FIFO_READ && !line_ready;

      // Read side: the last pop releases the bank; line_ready drops next cycle.
      if (pop) begin
        rd_sel <= rd_bank;
        if (rcnt == LAST) begin
          rcnt       <= '0;
          line_ready <= 1'b0;
        end else begin
          rcnt <= rcnt + CNT_W'(1);
        end
      end

      case (w_state)
        W_IDLE: begin
          if (accept && up.in_sof) begin
            wr_angle <= up.in_data;
            wcnt     <= '0;
            w_state  <= W_FILL;
          end
        end
        W_FILL: begin
          if (accept) begin
            if (up.in_sof) begin
              err_short <= 1'b1;
              wr_angle  <= up.in_data;
              wcnt      <= '0;
            end else if (wcnt == LAST) begin
              wcnt        <= '0;
              w_state     <= W_HOLD;
              up.in_ready <= 1'b0;
            end else begin
              wcnt <= wcnt + CNT_W'(1);
            end
          end
        end
        W_HOLD: begin
          // A repeat of the published angle would be invisible downstream, so drop it.
          if (wr_angle == angle) begin
            err_dup     <= 1'b1;
            w_state     <= W_IDLE;
            up.in_ready <= 1'b1;
          end else if (!line_ready) begin
            angle       <= wr_angle;
            line_ready  <= 1'b1;
            rd_bank     <= wr_bank;
            wr_bank     <= ~wr_bank;
            w_state     <= W_IDLE;
            up.in_ready <= 1'b1;
          end
        end
        default: begin
          w_state     <= W_IDLE;
          up.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_line_buffer.sv
// Self-checking bench for sweep_line_buffer: line table plus hand-written corner sequences.
module tb_sweep_line_buffer;
  import sweep_pkg::*;

  localparam int unsigned N = SIZE_ARINC;

  logic                clk = 1'b0;
  logic                rst;
  logic                fifo_read;
  logic [ANGLE_W-1:0]  angle;
  logic                line_ready;
  logic [DATA_W-1:0]   sample_out;
  logic                sample_valid;
  logic                err_short;
  logic                err_dup;
  logic                err_underflow;

  sweep_line_buffer_if bus ();

  sweep_line_buffer #(.SIZE_ARINC(N), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .up            (bus),
    .angle         (angle),
    .line_ready    (line_ready),
    .FIFO_READ     (fifo_read),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .err_short     (err_short),
    .err_dup       (err_dup),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cnt_short = 0;
  int unsigned cnt_dup   = 0;
  int unsigned cnt_uf    = 0;
  logic [DATA_W-1:0] sb [$];

  typedef struct {
    logic [ANGLE_W-1:0] hdr;
    int unsigned        n;
    int unsigned        off;
    logic [ANGLE_W-1:0] exp_angle;
    logic               exp_ready;
    int unsigned        exp_short;
    int unsigned        exp_dup;
    bit                 do_pop;
    int unsigned        pop_off;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and account for everything the DUT produced.
  task automatic tick();
    @(negedge clk);
    if (err_short)     cnt_short++;
    if (err_dup)       cnt_dup++;
    if (err_underflow) cnt_uf++;
    if (sample_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sample: got 0x%0h, expected no sample (t=%0t)", sample_out, $time);
      end else begin
        check("sample", 32'(sample_out), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic send_word(input bit sof, input logic [ANGLE_W-1:0] d);
    int g = 0;
    while (!bus.in_ready && g < 4 * N) begin
      tick();
      g++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready 0, expected 1 within %0d cycles", 4 * N);
    end else begin
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
    end
  endtask

  // Upper nibble of sample words carries junk that must be ignored.
  task automatic send_line(input logic [ANGLE_W-1:0] hdr, input int unsigned n, input int unsigned off);
    send_word(1'b1, hdr);
    for (int i = 0; i < int'(n); i++) send_word(1'b0, {4'(i + 5), 8'(i + int'(off))});
  endtask

  task automatic pop_line(input int unsigned n, input int unsigned off);
    for (int i = 0; i < int'(n); i++) begin
      fifo_read = 1'b1;
      sb.push_back(DATA_W'(i + int'(off)));
      tick();
    end
    fifo_read = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int g = 0;
    while (!line_ready && g < budget) begin
      tick();
      g++;
    end
    check("wait_line_ready", 32'(line_ready), 32'd1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_angle", 32'(angle), 32'h000);
    check("rst_line_ready", 32'(line_ready), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_err_short", 32'(err_short), 32'd0);
    check("rst_err_dup", 32'(err_dup), 32'd0);
    check("rst_err_underflow", 32'(err_underflow), 32'd0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    cnt_short = 0;
    cnt_dup   = 0;
    cnt_uf    = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned uf_base;

    vt[0] = '{12'h010, N,   0,   12'h010, 1'b1, 0, 0, 1'b1, 0};
    vt[1] = '{12'h020, 100, 0,   12'h010, 1'b0, 0, 0, 1'b0, 0};
    vt[2] = '{12'h021, N,   50,  12'h021, 1'b1, 1, 0, 1'b1, 50};
    vt[3] = '{12'h030, N,   7,   12'h030, 1'b1, 1, 0, 1'b0, 0};
    vt[4] = '{12'h030, N,   9,   12'h030, 1'b1, 1, 1, 1'b1, 7};
    vt[5] = '{12'h031, N,   200, 12'h031, 1'b1, 1, 1, 1'b1, 200};

    rst          = 1'b0;
    fifo_read    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    do_reset();

    foreach (vt[k]) begin
      send_line(vt[k].hdr, vt[k].n, vt[k].off);
      repeat (4) tick();
      check("tbl_angle", 32'(angle), 32'(vt[k].exp_angle));
      check("tbl_line_ready", 32'(line_ready), 32'(vt[k].exp_ready));
      check("tbl_in_ready", 32'(bus.in_ready), 32'd1);
      check("tbl_err_short_count", cnt_short, vt[k].exp_short);
      check("tbl_err_dup_count", cnt_dup, vt[k].exp_dup);
      if (vt[k].do_pop) begin
        pop_line(N, vt[k].pop_off);
        check("tbl_drained", 32'(sb.size()), 32'd0);
        repeat (2) tick();
        check("tbl_line_done", 32'(line_ready), 32'd0);
      end
    end

    // Two lines back to back with no consumer: the second one stalls the writer.
    do_reset();
    send_line(12'h010, N, 0);
    send_line(12'h011, N, 100);
    repeat (3) tick();
    check("b2b_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("b2b_angle_first", 32'(angle), 32'h010);
    check("b2b_line_ready", 32'(line_ready), 32'd1);
    pop_line(N, 0);
    check("b2b_release_ready", 32'(line_ready), 32'd0);
    check("b2b_release_angle", 32'(angle), 32'h010);
    tick();
    check("b2b_publish_angle", 32'(angle), 32'h011);
    check("b2b_publish_ready", 32'(line_ready), 32'd1);
    check("b2b_in_ready_back", 32'(bus.in_ready), 32'd1);
    pop_line(N, 100);
    check("b2b_drained", 32'(sb.size()), 32'd0);
    tick();

    // Popping with nothing published.
    uf_base   = cnt_uf;
    fifo_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("uf_sample_valid", 32'(sample_valid), 32'd0);
    end
    fifo_read = 1'b0;
    tick();
    check("uf_pulse_count", cnt_uf - uf_base, 32'd5);

    // Reset in the middle of draining a line, then a fresh line.
    send_line(12'h040, N, 3);
    wait_ready(8);
    check("mid_angle", 32'(angle), 32'h040);
    pop_line(300, 3);
    check("mid_drained", 32'(sb.size()), 32'd0);
    do_reset();
    send_line(12'h010, N, 0);
    wait_ready(8);
    check("post_rst_angle", 32'(angle), 32'h010);
    pop_line(N, 0);
    check("post_rst_drained", 32'(sb.size()), 32'd0);
    tick();
    check("post_rst_line_done", 32'(line_ready), 32'd0);
    check("post_rst_no_errors", cnt_short + cnt_dup + cnt_uf, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
